// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: one load/store per request, range/alignment trapping,
// read-data formatting and flush squashing of pending load responses.
module mem_access_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
  parameter int unsigned MEM_DEPTH   = 1048576,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic [1:0]  mem_access_size,
  output logic        mem_dm_byte,
  output logic        mem_dm_half,
  output logic        mem_rw,
  output logic        mem_enable,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(MEM_DEPTH);

  state_t      state, state_next;
  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic [2:0]  req_bytes;
  logic [32:0] req_end;
  logic        signed_q;
  logic        err_q;
  logic        squash_q;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign req_ready       = (state == IDLE) && !flush;
  assign accept          = req_valid && req_ready;
  assign mem_access_size = 2'b00;

  // Legality is judged on the live request so an illegal one can skip ACCESS.
  always_comb begin
    unique case (req_size)
      2'b00:   req_bytes = 3'd1;
      2'b01:   req_bytes = 3'd2;
      default: req_bytes = 3'd4;
    endcase
  end

  assign req_end    = {1'b0, req_addr} + {30'd0, req_bytes};
  assign misaligned = CHECK_ALIGN &&
                      (((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)));
  assign illegal    = (req_addr < BASE_ADDR) || (req_end > LIMIT) ||
                      (req_size == 2'b11) || misaligned;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_rw      <= 1'b1;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_dm_byte <= 1'b0;
      mem_dm_half <= 1'b0;
      signed_q    <= 1'b0;
      resp_rd     <= '0;
      err_q       <= 1'b0;
      squash_q    <= 1'b0;
    end else if (accept) begin
      mem_rw      <= req_rw;
      mem_address <= req_addr;
      mem_data_in <= req_wdata;
      mem_dm_byte <= (req_size == 2'b00);
      mem_dm_half <= (req_size == 2'b01);
      signed_q    <= req_signed;
      resp_rd     <= req_rd;
      err_q       <= illegal;
      squash_q    <= 1'b0;
    end else if ((state == ACCESS) && flush && mem_rw) begin
      // A load flushed during ACCESS must stay silent in RESP even if flush drops.
      squash_q <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    mem_enable = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_next = illegal ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_enable = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = !squash_q && !(flush && (mem_rw || err_q));
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory lane layout: byte A in [31:24], byte A+1 in [23:16].
  assign rd_byte = mem_data_out[31:24];
  assign rd_half = {mem_data_out[23:16], mem_data_out[31:24]};

  always_comb begin
    resp_rdata = '0;
    if (resp_valid && mem_rw && !err_q) begin
      if (mem_dm_byte)      resp_rdata = {{24{signed_q & rd_byte[7]}}, rd_byte};
      else if (mem_dm_half) resp_rdata = {{16{signed_q & rd_half[15]}}, rd_half};
      else                  resp_rdata = mem_data_out;
    end
  end

  assign resp_err = resp_valid && err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, flush/reset
// sequences, and random requests against a transaction-level byte model.
module tb_mem_access_ctrl;

  localparam logic [31:0] BASE  = 32'h8002_0000;
  localparam longint      DEPTH = 1048576;
  localparam logic [31:0] TOP   = 32'h8012_0000;

  logic        clock, reset_n;
  logic        req_valid, req_ready, req_rw, req_signed, flush;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic [1:0]  mem_access_size;
  logic        mem_dm_byte, mem_dm_half, mem_rw, mem_enable;

  int checks   = 0;
  int failures = 0;

  mem_access_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .flush(flush),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .resp_err(resp_err), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_access_size(mem_access_size), .mem_dm_byte(mem_dm_byte),
    .mem_dm_half(mem_dm_half), .mem_rw(mem_rw), .mem_enable(mem_enable),
    .mem_data_out(mem_data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pin-level memory: byte A on [31:24]; word stores place data[31:24] at A.
  bit [7:0] phys [int unsigned];
  initial mem_data_out = '0;

  function automatic bit [7:0] prd(input int unsigned a);
    return phys.exists(a) ? phys[a] : 8'h00;
  endfunction

  always @(posedge clock) begin
    if (mem_enable) begin
      if (!mem_rw) begin
        if (mem_dm_byte) begin
          phys[mem_address] = mem_data_in[7:0];
        end else if (mem_dm_half) begin
          phys[mem_address]     = mem_data_in[7:0];
          phys[mem_address + 1] = mem_data_in[15:8];
        end else begin
          phys[mem_address]     = mem_data_in[31:24];
          phys[mem_address + 1] = mem_data_in[23:16];
          phys[mem_address + 2] = mem_data_in[15:8];
          phys[mem_address + 3] = mem_data_in[7:0];
        end
      end else begin
        mem_data_out <= {prd(mem_address), prd(mem_address + 1),
                         prd(mem_address + 2), prd(mem_address + 3)};
      end
    end
  end

  // Transaction-level reference: what each legal store leaves behind.
  bit [7:0] model_mem [int unsigned];

  function automatic int unsigned mrd(input int unsigned a);
    return model_mem.exists(a) ? int'(model_mem[a]) : 0;
  endfunction

  function automatic bit model_illegal(input logic [1:0] size, input logic [31:0] addr);
    longint a = longint'(addr);
    longint n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (size == 2'd3) return 1'b1;
    if (a < longint'(BASE) || a + n > longint'(BASE) + DEPTH) return 1'b1;
    if (size == 2'd1 && (a % 2) != 0) return 1'b1;
    if (size == 2'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] d);
    int unsigned v = d;
    if (size == 2'd0) begin
      model_mem[addr] = 8'(v % 256);
    end else if (size == 2'd1) begin
      model_mem[addr]     = 8'(v % 256);
      model_mem[addr + 1] = 8'((v / 256) % 256);
    end else begin
      for (int k = 0; k < 4; k++) model_mem[addr + k] = 8'((v >> (8 * (3 - k))) % 256);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] addr);
    int unsigned v;
    if (size == 2'd0) begin
      v = mrd(addr);
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = mrd(addr) + 256 * mrd(addr + 1);
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = (mrd(addr) << 24) + (mrd(addr + 1) << 16) + (mrd(addr + 2) << 8) + mrd(addr + 3);
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_rw     = rw;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
  endtask

  // One complete request; returns sampling the response cycle.
  task automatic do_req(input string tag, input logic rw, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input logic [31:0] exp_rdata, input logic exp_err);
    int lat = 0;
    bit saw_en = 1'b0;
    @(negedge clock);
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    drive(rw, size, sgn, addr, wdata, rd);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (mem_enable) begin
        saw_en = 1'b1;
        check({tag, " addr"}, mem_address, addr);
        check({tag, " ctl"}, {27'd0, mem_rw, mem_dm_byte, mem_dm_half, mem_access_size},
              {27'd0, rw, size == 2'd0, size == 2'd1, 2'b00});
        if (!rw) check({tag, " wdata"}, mem_data_in, wdata);
      end
      if (resp_valid) begin
        lat = i;
        break;
      end
      @(negedge clock);
    end
    check({tag, " latency"}, 32'(lat), exp_err ? 32'd1 : 32'd2);
    check({tag, " enable_seen"}, 32'(saw_en), 32'(!exp_err));
    check({tag, " rdata"}, resp_rdata, exp_rdata);
    check({tag, " err_rd"}, {26'd0, resp_err, resp_rd}, {26'd0, exp_err, rd});
  endtask

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [17];

  initial begin
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h8002_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 2'd2, 1'b0, 32'h8002_0000, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h8002_0005, 32'h0000_00F0, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 2'd0, 1'b1, 32'h8002_0005, 32'h0,         32'hFFFF_FFF0, 1'b0};
    vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'h8002_0005, 32'h0,         32'h0000_00F0, 1'b0};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h8002_0010, 32'h0000_8123, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, 2'd1, 1'b1, 32'h8002_0010, 32'h0,         32'hFFFF_8123, 1'b0};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h8002_0010, 32'h0,         32'h0000_8123, 1'b0};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h8002_0002, 32'h0,         32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h8001_FFFC, 32'h0,         32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, 2'd3, 1'b0, 32'h8002_0000, 32'h0,         32'h0000_0000, 1'b1};
    vecs[11] = '{1'b1, 2'd2, 1'b0, 32'h8011_FFFC, 32'h0,         32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h8011_FFFF, 32'h0000_005A, 32'h0000_0000, 1'b0};
    vecs[13] = '{1'b1, 2'd0, 1'b0, 32'h8011_FFFF, 32'h0,         32'h0000_005A, 1'b0};
    vecs[14] = '{1'b1, 2'd2, 1'b0, 32'h8012_0000, 32'h0,         32'h0000_0000, 1'b1};
    vecs[15] = '{1'b0, 2'd2, 1'b0, 32'h8002_0001, 32'h1122_3344, 32'h0000_0000, 1'b1};
    vecs[16] = '{1'b1, 2'd2, 1'b0, 32'h8002_0000, 32'h0,         32'hDEAD_BEEF, 1'b0};

    reset_n = 1'b0;
    flush   = 1'b0;
    drive(1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0);
    req_valid = 1'b0;
    #12;
    check("reset ready_enable", {30'd0, req_ready, mem_enable}, 32'b10);
    check("reset resp", {26'd0, resp_valid, resp_err, resp_rd}, 32'd0);
    check("reset rdata", resp_rdata, 32'd0);
    check("reset mem_ctl", {28'd0, mem_rw, mem_dm_byte, mem_dm_half, mem_access_size == 2'b00},
          32'b1001);
    check("reset mem_addr", mem_address, 32'd0);
    check("reset mem_din", mem_data_in, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].rw, vecs[i].size, vecs[i].sgn, vecs[i].addr,
             vecs[i].wdata, 5'(i), vecs[i].exp_rdata, vecs[i].exp_err);
      if (!vecs[i].rw && !vecs[i].exp_err) model_store(vecs[i].size, vecs[i].addr, vecs[i].wdata);
    end

    // Load flushed in ACCESS: silent RESP, then ready straight after.
    @(negedge clock);
    drive(1'b1, 2'd2, 1'b0, BASE, 32'h0, 5'd7);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check("flushA enable", 32'(mem_enable), 32'd1);
    flush = 1'b1;
    #1 check("flushA ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    flush = 1'b0;
    #1 check("flushA resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clock);
    check("flushA ready_after", 32'(req_ready), 32'd1);

    // Load flushed only during RESP.
    drive(1'b1, 2'd2, 1'b0, BASE, 32'h0, 5'd8);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    flush = 1'b1;
    #1 check("flushR resp_valid", 32'(resp_valid), 32'd0);
    flush = 1'b0;

    // Store flushed in ACCESS still commits and still responds.
    @(negedge clock);
    drive(1'b0, 2'd2, 1'b0, 32'h8002_0020, 32'hCAFE_F00D, 5'd9);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clock);
    #1 check("flushS resp_valid", 32'(resp_valid), 32'd1);
    flush = 1'b0;
    model_store(2'd2, 32'h8002_0020, 32'hCAFE_F00D);
    do_req("flushS readback", 1'b1, 2'd2, 1'b0, 32'h8002_0020, 32'h0, 5'd10,
           32'hCAFE_F00D, 1'b0);

    // Flush blocks acceptance in IDLE.
    @(negedge clock);
    flush = 1'b1;
    drive(1'b1, 2'd2, 1'b0, BASE, 32'h0, 5'd11);
    #1 check("flushI ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    check("flushI not_accepted", {30'd0, mem_enable, resp_valid}, 32'd0);
    req_valid = 1'b0;
    flush = 1'b0;

    // Error response suppressed by flush.
    @(negedge clock);
    drive(1'b1, 2'd2, 1'b0, 32'h8002_0002, 32'h0, 5'd12);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    flush = 1'b1;
    #1 check("flushE resp_valid", 32'(resp_valid), 32'd0);
    flush = 1'b0;

    // Reset during ACCESS drops enable immediately.
    @(negedge clock);
    drive(1'b1, 2'd2, 1'b0, BASE, 32'h0, 5'd13);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check("rstA enable_before", 32'(mem_enable), 32'd1);
    #1 reset_n = 1'b0;
    #1 check("rstA enable_now", {30'd0, mem_enable, resp_valid}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1 check("rstA after", {30'd0, req_ready, mem_rw}, 32'b11);
    check("rstA addr", mem_address, 32'd0);

    for (int n = 0; n < 300; n++) begin
      logic        rw, sgn, err;
      logic [1:0]  size;
      logic [31:0] addr, wdata, exp;
      logic [4:0]  rd;
      rw   = 1'($urandom_range(0, 1));
      sgn  = 1'($urandom_range(0, 1));
      size = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       addr = BASE - 32'($urandom_range(1, 8));
        1:       addr = TOP - 32'($urandom_range(0, 8));
        default: addr = BASE + 32'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
      end
      wdata = $urandom;
      rd    = 5'($urandom_range(0, 31));
      err   = model_illegal(size, addr);
      exp   = (rw && !err) ? model_load(size, sgn, addr) : 32'd0;
      do_req($sformatf("rnd%0d", n), rw, size, sgn, addr, wdata, rd, exp, err);
      if (!rw && !err) model_store(size, addr, wdata);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
